uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial receive front end for the memory-mapped peripheral block. It samples the external `rx` pin, deframes 8N1 UART characters and buffers the received bytes in a small FIFO. The peripheral register file then drains the FIFO via a pop strobe. It also provides the receive interrupt level and sticky error flags that the peripheral exposes to software.

## Interface
- `DIV`, 325 — clk cycles per oversample tick; baud = f_clk / (16·DIV); legal range ≥ 2
- `DEPTH`, 4 — FIFO entries; power of two, ≥ 2
- `clk` in 1 — single clock, all logic on rising edge
- `reset` in 1 — synchronous, active-high; clears all state
- `rx` in 1 — asynchronous serial input, idle high
- `rd_pop` in 1 — consume head byte (peripheral read of RX data register)
- `err_clr` in 1 — clear sticky error flags
- `rd_data` out 8 — FIFO head byte (show-ahead); 0 at reset
- `rd_valid` out 1 — FIFO non-empty; 0 at reset
- `frame_err` out 1 — sticky: stop bit sampled low; 0 at reset
- `overrun` out 1 — sticky: byte lost because FIFO full; 0 at reset
- `irq` out 1 — equals `rd_valid`; 0 at reset

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1); all logic uses `rx_s`.
- Tick generator: free-running counter 0..DIV-1; `tick` asserts for one clk when count = DIV-1. Cleared by reset only.
- Bit timing: 4-bit sample counter `sc`, advanced on each `tick`. Each bit occupies 16 ticks. Bit value = majority of `rx_s` at `sc` = 7, 8, 9.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on a tick with `rx_s`=0, set `sc`←0 and go to START.
  - START: at `sc`=15, go to DATA if the majority is 0; otherwise treat as a glitch and go to IDLE.
  - DATA: shift the majority into the shift register LSB-first at `sc`=15. After 8 bits, go to STOP.
  - STOP: decide at `sc`=9, not 15, so back-to-back frames are tolerated.
    - Majority 1: push the byte and go to IDLE.
    - Majority 0: set `frame_err`, drop the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents break conditions from producing garbage frames.
- FIFO: `DEPTH` entries with read and write pointers that wrap modulo DEPTH. Keep an occupancy count of width log2(DEPTH)+1.
  - `rd_pop` with FIFO empty: ignored; no pointer change.
  - Push with FIFO full and no pop in the same cycle: byte dropped, `overrun` set, FIFO unchanged.
  - Push and pop in the same cycle: both take effect and occupancy is unchanged. This holds when full (no overrun) and when empty with a valid head? No — an empty FIFO cannot pop, so push alone takes effect.
- Sticky flags: `err_clr` clears both flags. If a set event and `err_clr` occur in the same cycle, set wins.
- Reset mid-frame: FSM→IDLE, FIFO emptied, flags cleared, partial byte discarded. No push occurs on the reset cycle.

## Timing
- `rd_valid`/`rd_data` update on the clk edge after the STOP decision tick. There is no combinational path from `rx` to any output.
- Pin-to-`rd_valid` latency after the start falling edge: 2 sync cycles, plus ≤ DIV cycles of tick phase, plus (9·16+10)·DIV cycles, plus 1.
- Pop is registered: after `rd_pop`, the next head appears on `rd_data` the following cycle. If only one entry remained, `rd_valid` drops that cycle.
- `rd_data` holds its last value when the FIFO is empty; the contents are don't-care.
- `irq` is a level that follows `rd_valid` with zero added latency.

## Structure
- Package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP, WAIT_HIGH)
  - `OVERSAMPLE` = 16
  - sample points `SMP_LO`=7, `SMP_MID`=8, `SMP_HI`=9
  - `BIT_END`=15
  - `DATA_BITS`=8
- Sub-module `sync_fifo` (width 8, parameter DEPTH) carries the push/pop/full/empty logic. The top-level block holds the synchronizer, tick generator, FSM and flags.

## Test plan
Use DIV=4 (64 clk per bit).
- Send 0xA5 as 8N1 → `rd_valid`=1 and `rd_data`=0xA5 exactly once; `frame_err`=0; `irq`=1. After `rd_pop`, `rd_valid`=0 on the next cycle.
- Pulse `rx` low for 20 clk (< half bit) → FSM returns to IDLE and nothing is pushed.
- Send 0x3C with the stop bit held low, then keep `rx` low for 3 bit times → `frame_err`=1, nothing pushed, no further frames. Restore `rx` and send 0x11 → 0x11 is received. Pulse `err_clr` → `frame_err`=0.
- Send 5 bytes 0x01–0x05 back-to-back with no pops (DEPTH=4) → FIFO holds 0x01–0x04 and `overrun`=1. Pops return 0x01, 0x02, 0x03, 0x04 in order.
- With FIFO full, assert `rd_pop` in the exact push cycle of a fifth byte → no overrun, and occupancy stays 4.
- Assert `reset` for 1 cycle midway through the DATA bits of 0xFF → all outputs are 0 and `rd_valid` stays 0. The next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, oversampling
// constants and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  SMP_LO     = 4'd7;
  localparam logic [3:0]  SMP_MID    = 4'd8;
  localparam logic [3:0]  SMP_HI     = 4'd9;
  localparam logic [3:0]  BIT_END    = 4'(OVERSAMPLE - 1);
  localparam int unsigned DATA_BITS  = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered show-ahead head byte.
// Simultaneous push and pop both succeed, including when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    rptr_inc;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             pop_eff;
  logic             push_eff;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign overflow = push & full & ~pop_eff;
  assign valid    = ~empty;
  assign rptr_inc = rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push_eff) mem[wptr] <= din;
  end

  // dout is loaded with the byte that becomes head after this edge,
  // so it simply holds its last value once the FIFO drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (push_eff) wptr <= wptr + 1'b1;
      if (pop_eff)  rptr <= rptr_inc;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop_eff) begin
        if (count > CW'(1))  dout <= mem[rptr_inc];
        else if (push_eff)   dout <= din;
      end else if (push_eff && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit decisions,
// receive FIFO and sticky frame/overrun error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DIV   = 325,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_pop,
  input  logic       err_clr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       irq
);

  localparam int unsigned DW = $clog2(DIV);

  logic          rx_m;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    sc;
  state_t        state;
  logic          s_lo;
  logic          s_mid;
  logic          bit_maj;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          stop_maj;
  logic          stop_tick;
  logic          push;
  logic          frame_set;
  logic          fifo_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) div_cnt <= '0;
    else       div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  // Stop bit is judged at SMP_HI using the live sample as the third vote,
  // leaving the rest of the stop bit free for a back-to-back start edge.
  assign stop_maj  = maj3(s_lo, s_mid, rx_s);
  assign stop_tick = tick && (state == STOP) && (sc == SMP_HI);
  assign push      = stop_tick & stop_maj;
  assign frame_set = stop_tick & ~stop_maj;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sc      <= '0;
      s_lo    <= 1'b1;
      s_mid   <= 1'b1;
      bit_maj <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (tick) begin
      sc <= sc + 1'b1;
      if (sc == SMP_LO)  s_lo    <= rx_s;
      if (sc == SMP_MID) s_mid   <= rx_s;
      if (sc == SMP_HI)  bit_maj <= maj3(s_lo, s_mid, rx_s);
      case (state)
        IDLE: begin
          sc <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (sc == BIT_END) begin
            bit_cnt <= '0;
            state   <= bit_maj ? IDLE : DATA;
          end
        end
        DATA: begin
          if (sc == BIT_END) begin
            shreg   <= {bit_maj, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
          end
        end
        STOP: begin
          if (sc == SMP_HI) state <= stop_maj ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (fifo_overflow) overrun <= 1'b1;
      else if (err_clr)  overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .din      (shreg),
    .pop      (rd_pop),
    .dout     (rd_data),
    .valid    (rd_valid),
    .overflow (fifo_overflow)
  );

  assign irq = rd_valid;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DIV=4 with a byte scoreboard queue.
module tb_uart_rx_fifo;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rd_pop;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overrun;
  logic       irq;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DIV   (4),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd_pop    (rd_pop),
    .err_clr   (err_clr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .irq       (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    cycles(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(BIT_CLK);
    end
    rx = stop_bit;
    cycles(BIT_CLK);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, 32'(rd_valid), 32'd0);
    end else begin
      chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
      e = exp_q.pop_front();
      chk(tag, 32'(rd_data), 32'(e));
      rd_pop = 1'b1;
      cycles(1);
      rd_pop = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
  endtask

  initial begin
    bit found;
    reset   = 1'b1;
    rx      = 1'b1;
    rd_pop  = 1'b0;
    err_clr = 1'b0;
    cycles(3);
    chk("rst_rd_valid",  32'(rd_valid),  32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    chk("rst_irq",       32'(irq),       32'd0);
    reset = 1'b0;
    cycles(10);

    // single good byte
    send_frame(8'hA5, 1'b1);
    exp_q.push_back(8'hA5);
    chk("a5_irq",       32'(irq),       32'd1);
    chk("a5_frame_err", 32'(frame_err), 32'd0);
    pop_check("a5_data");
    chk("a5_drained", 32'(rd_valid), 32'd0);
    chk("a5_irq_off", 32'(irq),      32'd0);
    cycles(2 * BIT_CLK);
    chk("a5_once", 32'(rd_valid), 32'd0);

    // short glitch is rejected
    rx = 1'b0;
    cycles(20);
    rx = 1'b1;
    cycles(3 * BIT_CLK);
    chk("glitch_no_push", 32'(rd_valid),  32'd0);
    chk("glitch_no_ferr", 32'(frame_err), 32'd0);

    // framing error followed by a break
    send_frame(8'h3C, 1'b0);
    cycles(3 * BIT_CLK);
    chk("ferr_set",     32'(frame_err), 32'd1);
    chk("ferr_no_push", 32'(rd_valid),  32'd0);
    rx = 1'b1;
    cycles(BIT_CLK);
    send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h11);
    pop_check("after_break");
    chk("ferr_sticky", 32'(frame_err), 32'd1);
    pulse_clr();
    chk("ferr_clr", 32'(frame_err), 32'd0);

    // five back-to-back bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      if (i <= 4) exp_q.push_back(8'(i));
    end
    chk("ovr_set",   32'(overrun),  32'd1);
    chk("ovr_valid", 32'(rd_valid), 32'd1);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ovr_pop%0d", i));
    chk("ovr_drained", 32'(rd_valid), 32'd0);
    pulse_clr();
    chk("ovr_clr", 32'(overrun), 32'd0);

    // full FIFO, pop coincides with the fifth push
    for (int i = 0; i < 4; i++) begin
      send_frame(8'(8'h21 + i), 1'b1);
      exp_q.push_back(8'(8'h21 + i));
    end
    chk("full_no_ovr", 32'(overrun), 32'd0);
    found = 1'b0;
    fork
      send_frame(8'h25, 1'b1);
      begin
        for (int k = 0; k < 12 * BIT_CLK && !found; k++) begin
          @(negedge clk);
          if (dut.push === 1'b1) found = 1'b1;
        end
        if (found) begin
          rd_pop = 1'b1;
          @(posedge clk);
          #1;
          rd_pop = 1'b0;
        end
      end
    join
    chk("coinc_push_seen", 32'(found), 32'd1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h25);
    chk("coinc_no_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("coinc_pop%0d", i));
    chk("coinc_drained", 32'(rd_valid), 32'd0);

    // reset in the middle of a frame
    send_frame(8'h77, 1'b1);
    exp_q.push_back(8'h77);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        cycles(4 * BIT_CLK);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        exp_q.delete();
        chk("midrst_valid",   32'(rd_valid),  32'd0);
        chk("midrst_data",    32'(rd_data),   32'd0);
        chk("midrst_irq",     32'(irq),       32'd0);
        chk("midrst_ferr",    32'(frame_err), 32'd0);
        chk("midrst_overrun", 32'(overrun),   32'd0);
      end
    join
    cycles(BIT_CLK);
    chk("midrst_still_empty", 32'(rd_valid), 32'd0);
    send_frame(8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    pop_check("post_rst");
    chk("post_rst_drained", 32'(rd_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
